// File: rtl/line_fifo_pkg.sv
// Shared definitions for the line-buffer read controller: FSM encodings and
// elaboration-time helpers used to size counters and the address ring.
package line_fifo_pkg;

  typedef logic [2:0] fsm_state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_ADV   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  // Number of output rows one image produces for a given window height and stride.
  function automatic int out_rows(input int img_lines, input int matrix_size, input int stride);
    return (img_lines - matrix_size) / stride + 1;
  endfunction

  // Total buffer words in the line ring.
  function automatic int ring_words(input int num_lines, input int words_per_line);
    return num_lines * words_per_line;
  endfunction

endpackage

// File: rtl/line_fifo_addr_gen.sv
// Window read-address generator. Walks word-major, line-minor through the
// current window, keeping the top-line base and the current-line base as
// registers that step by a line (or a stride of lines) and wrap around the ring.
module line_fifo_addr_gen
  import line_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH     = 11,
  parameter int WORDS_PER_LINE = 57,
  parameter int NUM_LINES      = 15,
  parameter int MATRIX_SIZE    = 11,
  parameter int STRIDE         = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_clear,
  input  logic                  i_advance,
  input  logic                  i_step_row,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_last
);

  localparam int RING = ring_words(NUM_LINES, WORDS_PER_LINE);
  localparam int STEP = STRIDE * WORDS_PER_LINE;
  localparam int WW   = $clog2(WORDS_PER_LINE + 1);
  localparam int KW   = $clog2(MATRIX_SIZE + 1);

  logic [WW-1:0]         w;
  logic [KW-1:0]         k;
  logic [ADDR_WIDTH-1:0] top_base;
  logic [ADDR_WIDTH-1:0] cur_base;
  logic [ADDR_WIDTH:0]   cur_inc;
  logic [ADDR_WIDTH:0]   top_inc;
  logic [ADDR_WIDTH-1:0] cur_next_line;
  logic [ADDR_WIDTH-1:0] top_next;
  logic                  last_k;
  logic                  last_w;

  assign last_k    = (k == KW'(MATRIX_SIZE - 1));
  assign last_w    = (w == WW'(WORDS_PER_LINE - 1));
  assign o_last    = last_k & last_w;
  assign o_rd_addr = cur_base + ADDR_WIDTH'(w);

  // Next line base and next window top, each folded back into the ring with one subtract.
  always_comb begin
    cur_inc       = {1'b0, cur_base} + (ADDR_WIDTH+1)'(WORDS_PER_LINE);
    cur_next_line = (cur_inc >= (ADDR_WIDTH+1)'(RING)) ?
                    ADDR_WIDTH'(cur_inc - (ADDR_WIDTH+1)'(RING)) : ADDR_WIDTH'(cur_inc);
    top_inc       = {1'b0, top_base} + (ADDR_WIDTH+1)'(STEP);
    top_next      = (top_inc >= (ADDR_WIDTH+1)'(RING)) ?
                    ADDR_WIDTH'(top_inc - (ADDR_WIDTH+1)'(RING)) : ADDR_WIDTH'(top_inc);
  end

  // Word/line counters and base registers; a stalled cycle simply holds everything.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      w        <= '0;
      k        <= '0;
      top_base <= '0;
      cur_base <= '0;
    end else if (i_clear) begin
      w        <= '0;
      k        <= '0;
      top_base <= '0;
      cur_base <= '0;
    end else if (i_step_row) begin
      w        <= '0;
      k        <= '0;
      top_base <= top_next;
      cur_base <= top_next;
    end else if (i_advance) begin
      if (last_k) begin
        k        <= '0;
        cur_base <= top_base;
        w        <= last_w ? '0 : w + 1'b1;
      end else begin
        k        <= k + 1'b1;
        cur_base <= cur_next_line;
      end
    end
  end

endmodule

// File: rtl/line_fifo_rd_ctrl.sv
// Line-buffer read controller: counts buffered lines from the ingest side,
// pulses the write-address reset at ring wrap, issues window reads per output
// row, retires STRIDE lines after each row and drains the read pipe at image end.
module line_fifo_rd_ctrl
  import line_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH     = 11,
  parameter int WORDS_PER_LINE = 57,
  parameter int NUM_LINES      = 15,
  parameter int MATRIX_SIZE    = 11,
  parameter int STRIDE         = 4,
  parameter int IMG_LINES      = 227,
  parameter int RD_LATENCY     = 2
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic                           i_start,
  input  logic                           i_line_done,
  output logic                           o_wr_addr_reset,
  output logic [$clog2(NUM_LINES+1)-1:0] o_space_avail,
  input  logic                           i_mlp_ready,
  output logic                           o_rd_en,
  output logic [ADDR_WIDTH-1:0]          o_rd_addr,
  output logic                           o_data_valid,
  output logic                           o_row_done,
  output logic                           o_img_done,
  output logic                           o_busy
);

  localparam int OUT_ROWS = out_rows(IMG_LINES, MATRIX_SIZE, STRIDE);
  localparam int LW       = $clog2(NUM_LINES + 1);
  localparam int RW       = $clog2(OUT_ROWS + 1);
  localparam int DW       = $clog2(RD_LATENCY + 1);

  fsm_state_t            state;
  fsm_state_t            state_next;
  logic [LW-1:0]         avail;
  logic [LW-1:0]         avail_next;
  logic [LW:0]           avail_sum;
  logic [LW-1:0]         wr_line;
  logic [LW-1:0]         space_q;
  logic [RW-1:0]         row;
  logic [DW-1:0]         drain_cnt;
  logic [RD_LATENCY-1:0] valid_pipe;
  logic                  rd_last;
  logic                  img_done;
  logic                  adv;
  logic                  line_inc;
  logic                  wrap_line;

  assign adv             = (state == ST_ADV);
  assign o_rd_en         = (state == ST_ISSUE) && i_mlp_ready && !i_start;
  assign o_row_done      = o_rd_en && rd_last;
  assign img_done        = (state == ST_DRAIN) && (drain_cnt == DW'(RD_LATENCY)) && !i_start;
  assign o_img_done      = img_done;
  assign o_busy          = (state != ST_IDLE);
  assign wrap_line       = i_line_done && (wr_line == LW'(NUM_LINES - 1));
  assign o_wr_addr_reset = i_start || wrap_line;
  assign o_space_avail   = space_q;
  assign o_data_valid    = valid_pipe[RD_LATENCY-1];
  assign line_inc        = i_line_done && (avail != LW'(NUM_LINES));

  line_fifo_addr_gen #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .NUM_LINES      (NUM_LINES),
    .MATRIX_SIZE    (MATRIX_SIZE),
    .STRIDE         (STRIDE)
  ) u_addr_gen (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_clear    (i_start || img_done),
    .i_advance  (o_rd_en),
    .i_step_row (adv),
    .o_rd_addr  (o_rd_addr),
    .o_last     (rd_last)
  );

  // Buffered-line count: +1 per finished line (saturating), -STRIDE when a row retires.
  always_comb begin
    avail_sum = {1'b0, avail} + (LW+1)'(line_inc);
    if (adv) begin
      avail_sum = (avail_sum >= (LW+1)'(STRIDE)) ? avail_sum - (LW+1)'(STRIDE) : '0;
    end
    avail_next = avail_sum[LW-1:0];
  end

  // Next-state logic; a start pulse from any state restarts the image in WAIT.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (i_start) state_next = ST_WAIT;
      ST_WAIT:  if (avail >= LW'(MATRIX_SIZE)) state_next = ST_ISSUE;
      ST_ISSUE: if (o_row_done) state_next = ST_ADV;
      ST_ADV:   state_next = (row == RW'(OUT_ROWS - 1)) ? ST_DRAIN : ST_WAIT;
      ST_DRAIN: if (img_done) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (i_start) state_next = ST_WAIT;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= state_next;
  end

  // Drain timer: counts the read latency after the final row before signalling image end.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                                      drain_cnt <= '0;
    else if ((state == ST_DRAIN) && !img_done && !i_start) drain_cnt <= drain_cnt + 1'b1;
    else                                                 drain_cnt <= '0;
  end

  // Line accounting: write-line index, buffered count, free space and output row.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      avail   <= '0;
      wr_line <= '0;
      row     <= '0;
      space_q <= LW'(NUM_LINES);
    end else if (i_start || img_done) begin
      avail   <= '0;
      wr_line <= '0;
      row     <= '0;
      space_q <= LW'(NUM_LINES);
    end else begin
      if (i_line_done) wr_line <= wrap_line ? '0 : wr_line + 1'b1;
      if (adv)         row     <= row + 1'b1;
      avail   <= avail_next;
      space_q <= LW'(NUM_LINES) - avail_next;
    end
  end

  // Read-valid delay line matching the buffer read latency; flushed on restart.
  if (RD_LATENCY == 1) begin : g_pipe1
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)   valid_pipe <= '0;
      else if (i_start) valid_pipe <= '0;
      else              valid_pipe <= o_rd_en;
    end
  end else begin : g_pipen
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)   valid_pipe <= '0;
      else if (i_start) valid_pipe <= '0;
      else              valid_pipe <= {valid_pipe[RD_LATENCY-2:0], o_rd_en};
    end
  end

`ifndef SYNTHESIS
  // Writer must never finish a line while every ring slot is still occupied.
  always @(posedge i_clk) begin
    if (i_reset_n && i_line_done && !i_start) assert (avail != LW'(NUM_LINES));
  end
`endif

endmodule

// File: tb/tb_line_fifo_rd_ctrl.sv
// Bench for line_fifo_rd_ctrl: a small-ring instance for ordering, stall,
// space, abort and reset behaviour, plus a four-line ring instance for wrap.
// Expected read addresses are queued when lines are fed and popped per read.
module tb_line_fifo_rd_ctrl;

  localparam int AW   = 11;
  localparam int WPL  = 4;
  localparam int NL   = 6;
  localparam int MS   = 3;
  localparam int ST   = 1;
  localparam int IMG  = 5;
  localparam int RDL  = 2;
  localparam int NL_B = 4;
  localparam int IMG_B = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic          start_a = 1'b0, line_done_a = 1'b0, ready_a = 1'b0;
  logic          wr_addr_reset_a, rd_en_a, data_valid_a, row_done_a, img_done_a, busy_a;
  logic [2:0]    space_a;
  logic [AW-1:0] rd_addr_a;

  logic          start_b = 1'b0, line_done_b = 1'b0, ready_b = 1'b0;
  logic          wr_addr_reset_b, rd_en_b, data_valid_b, row_done_b, img_done_b, busy_b;
  logic [2:0]    space_b;
  logic [AW-1:0] rd_addr_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int reads_a = 0;
  int reads_b = 0;
  int last_valid_a = -100;
  int q_a[$];
  int q_b[$];
  bit hist0 = 1'b0;
  bit hist1 = 1'b0;

  always #5 clk = ~clk;

  line_fifo_rd_ctrl #(
    .ADDR_WIDTH(AW), .WORDS_PER_LINE(WPL), .NUM_LINES(NL), .MATRIX_SIZE(MS),
    .STRIDE(ST), .IMG_LINES(IMG), .RD_LATENCY(RDL)
  ) u_dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start_a), .i_line_done(line_done_a),
    .o_wr_addr_reset(wr_addr_reset_a), .o_space_avail(space_a), .i_mlp_ready(ready_a),
    .o_rd_en(rd_en_a), .o_rd_addr(rd_addr_a), .o_data_valid(data_valid_a),
    .o_row_done(row_done_a), .o_img_done(img_done_a), .o_busy(busy_a)
  );

  line_fifo_rd_ctrl #(
    .ADDR_WIDTH(AW), .WORDS_PER_LINE(WPL), .NUM_LINES(NL_B), .MATRIX_SIZE(MS),
    .STRIDE(ST), .IMG_LINES(IMG_B), .RD_LATENCY(RDL)
  ) u_dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start_b), .i_line_done(line_done_b),
    .o_wr_addr_reset(wr_addr_reset_b), .o_space_avail(space_b), .i_mlp_ready(ready_b),
    .o_rd_en(rd_en_b), .o_rd_addr(rd_addr_b), .o_data_valid(data_valid_b),
    .o_row_done(row_done_b), .o_img_done(img_done_b), .o_busy(busy_b)
  );

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Queue the expected reads (bit 16 flags the row's last read) for nrows windows.
  task automatic push_rows(input bit to_b, input int nrows, input int nl);
    int top;
    int e;
    for (int r = 0; r < nrows; r++) begin
      top = (r * ST) % nl;
      for (int w = 0; w < WPL; w++) begin
        for (int k = 0; k < MS; k++) begin
          e = ((top + k) % nl) * WPL + w;
          if ((w == WPL - 1) && (k == MS - 1)) e = e | (1 << 16);
          if (to_b) q_b.push_back(e);
          else      q_a.push_back(e);
        end
      end
    end
  endtask

  // Pulse n back-to-back line completions on instance A, checking the wrap reset.
  task automatic applyStimulus(input int n, input int wrap_idx);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      line_done_a = 1'b1;
      @(negedge clk);
      checkOutput("wr_addr_reset_a", 32'(wr_addr_reset_a), 32'(i == wrap_idx));
    end
    @(posedge clk); #1;
    line_done_a = 1'b0;
  endtask

  always @(posedge clk) cyc++;

  // Instance A monitor: read scoreboard plus the expected valid delay line.
  always @(negedge clk) begin
    int e;
    if (!rst_n) begin
      hist0 = 1'b0;
      hist1 = 1'b0;
    end else begin
      checkOutput("data_valid_a", 32'(data_valid_a), 32'(hist1));
      if (data_valid_a) last_valid_a = cyc;
      if (start_a) begin
        hist1 = 1'b0;
        hist0 = 1'b0;
      end else begin
        hist1 = hist0;
        hist0 = rd_en_a;
      end
      if (rd_en_a) begin
        reads_a++;
        if (q_a.size() == 0) checkOutput("rd_unexpected_a", 32'(rd_en_a), 32'd0);
        else begin
          e = q_a.pop_front();
          checkOutput("rd_addr_a", 32'(rd_addr_a), e & 32'hffff);
          checkOutput("row_done_a", 32'(row_done_a), (e >> 16) & 1);
        end
      end else checkOutput("row_done_idle_a", 32'(row_done_a), 32'd0);
    end
  end

  // Instance B monitor: read scoreboard only.
  always @(negedge clk) begin
    int e;
    if (rst_n && rd_en_b) begin
      reads_b++;
      if (q_b.size() == 0) checkOutput("rd_unexpected_b", 32'(rd_en_b), 32'd0);
      else begin
        e = q_b.pop_front();
        checkOutput("rd_addr_b", 32'(rd_addr_b), e & 32'hffff);
        checkOutput("row_done_b", 32'(row_done_b), (e >> 16) & 1);
      end
    end
  end

  // Hard stop in case a bounded wait is ever bypassed.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence.
  initial begin
    bit seen;
    int base;
    int fed;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_space_a", 32'(space_a), 32'd6);
    checkOutput("rst_space_b", 32'(space_b), 32'd4);
    checkOutput("rst_rd_en", 32'(rd_en_a), 32'd0);
    checkOutput("rst_busy", 32'(busy_a), 32'd0);
    checkOutput("rst_wr_reset", 32'(wr_addr_reset_a), 32'd0);
    checkOutput("rst_img_done", 32'(img_done_a), 32'd0);

    // Full image with a full ring, a mid-row stall and space tracking.
    @(posedge clk); #1 start_a = 1'b1;
    @(negedge clk);
    checkOutput("start_wr_reset", 32'(wr_addr_reset_a), 32'd1);
    @(posedge clk); #1 start_a = 1'b0;
    checkOutput("busy_after_start", 32'(busy_a), 32'd1);
    push_rows(1'b0, 3, NL);
    applyStimulus(6, 5);
    @(negedge clk);
    checkOutput("space_full", 32'(space_a), 32'd0);
    checkOutput("no_rd_not_ready", 32'(rd_en_a), 32'd0);
    @(posedge clk); #1 ready_a = 1'b1;
    for (int i = 0; i < 50 && reads_a < 5; i++) begin
      @(posedge clk); #1;
    end
    ready_a = 1'b0;
    checkOutput("reads_before_stall", 32'(reads_a >= 5), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_rd_en", 32'(rd_en_a), 32'd0);
      checkOutput("stall_addr", 32'(rd_addr_a), q_a[0] & 32'hffff);
    end
    @(posedge clk); #1 ready_a = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (row_done_a) seen = 1'b1;
    end
    checkOutput("row0_done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("space_after_row0", 32'(space_a), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (img_done_a) seen = 1'b1;
    end
    checkOutput("img_done_a_seen", 32'(seen), 32'd1);
    checkOutput("img_done_delay", 32'(cyc - last_valid_a), 32'd2);
    checkOutput("q_a_drained", 32'(q_a.size()), 32'd0);
    @(negedge clk);
    checkOutput("busy_after_img", 32'(busy_a), 32'd0);
    checkOutput("space_after_img", 32'(space_a), 32'd6);

    // Start latency, then abort mid-row.
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    push_rows(1'b0, 1, NL);
    applyStimulus(3, -1);
    @(negedge clk);
    checkOutput("latency_wait", 32'(rd_en_a), 32'd0);
    @(negedge clk);
    checkOutput("latency_first", 32'(rd_en_a), 32'd1);
    base = reads_a;
    for (int i = 0; i < 50 && reads_a < base + 3; i++) begin
      @(posedge clk); #1;
    end
    start_a = 1'b1;
    @(negedge clk);
    checkOutput("abort_wr_reset", 32'(wr_addr_reset_a), 32'd1);
    @(posedge clk); #1 start_a = 1'b0;
    q_a.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort_rd_en", 32'(rd_en_a), 32'd0);
      checkOutput("abort_busy", 32'(busy_a), 32'd1);
    end
    checkOutput("abort_space", 32'(space_a), 32'd6);

    // Restarted window begins at line 0; async reset mid-row.
    push_rows(1'b0, 1, NL);
    applyStimulus(3, -1);
    base = reads_a;
    for (int i = 0; i < 50 && reads_a < base + 6; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("reads_before_reset", 32'(reads_a >= base + 6), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("areset_rd_en", 32'(rd_en_a), 32'd0);
    checkOutput("areset_rd_addr", 32'(rd_addr_a), 32'd0);
    checkOutput("areset_valid", 32'(data_valid_a), 32'd0);
    checkOutput("areset_busy", 32'(busy_a), 32'd0);
    checkOutput("areset_row_done", 32'(row_done_a), 32'd0);
    checkOutput("areset_space", 32'(space_a), 32'd6);
    q_a.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ready_a = 1'b0;
    repeat (4) @(negedge clk);

    // Four-line ring: writer paced by free space, wrap reset on the fourth line.
    push_rows(1'b1, 4, NL_B);
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    ready_b = 1'b1;
    fed = 0;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk); #1;
      if (fed < IMG_B && space_b != 3'd0) begin
        line_done_b = 1'b1;
        @(negedge clk);
        checkOutput("wr_addr_reset_b", 32'(wr_addr_reset_b), 32'(fed == 3));
        fed++;
      end else begin
        line_done_b = 1'b0;
        @(negedge clk);
      end
      if (img_done_b) seen = 1'b1;
    end
    line_done_b = 1'b0;
    checkOutput("img_done_b_seen", 32'(seen), 32'd1);
    checkOutput("lines_fed_b", 32'(fed), 32'd6);
    checkOutput("q_b_drained", 32'(q_b.size()), 32'd0);
    checkOutput("reads_b_total", 32'(reads_b), 32'(4 * WPL * MS));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
